// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - frame sequencer between word_rx, the ALU and word_tx
module calc_seq_ctrl #(
    parameter int EXEC_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter bit SEND_HI        = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_lo,
    input  logic [31:0] alu_hi,
    output logic [31:0] tx_word,
    output logic        tx_send,
    input  logic        tx_done,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun,
    output logic [2:0]  state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [EW-1:0] EX_LAST = EW'(EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_B   = 3'd1,
        ST_GET_OP  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND_LO = 3'd4,
        ST_WAIT_LO = 3'd5,
        ST_SEND_HI = 3'd6,
        ST_WAIT_HI = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   alu_a_q, alu_a_d;
    logic [31:0]   alu_b_q, alu_b_d;
    logic [3:0]    alu_op_q, alu_op_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   tx_word_q, tx_word_d;
    logic          tx_send_q, tx_send_d;
    logic          busy_q, busy_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [EW-1:0] ex_cnt_q, ex_cnt_d;

    // Next-state and registered-output logic; every output is a flop so the
    // debug state, busy and the tx_send pulse line up cycle-for-cycle.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        tx_word_d   = tx_word_q;
        to_cnt_d    = to_cnt_q;
        ex_cnt_d    = ex_cnt_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (word_valid) begin
                    alu_a_d  = word_in;
                    to_cnt_d = '0;
                    state_d  = ST_GET_B;
                end
            end
            ST_GET_B: begin
                // An arriving word beats a timeout in the same cycle.
                if (word_valid) begin
                    alu_b_d  = word_in;
                    to_cnt_d = '0;
                    state_d  = ST_GET_OP;
                end else if (to_cnt_q == TO_LAST) begin
                    frame_err_d = 1'b1;
                    to_cnt_d    = '0;
                    state_d     = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            ST_GET_OP: begin
                if (word_valid) begin
                    alu_op_d = word_in[3:0];
                    ex_cnt_d = EX_LAST;
                    to_cnt_d = '0;
                    state_d  = ST_EXEC;
                end else if (to_cnt_q == TO_LAST) begin
                    frame_err_d = 1'b1;
                    to_cnt_d    = '0;
                    state_d     = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            ST_EXEC: begin
                // Result is sampled on the last settle cycle; tx_word is
                // loaded alongside so it is valid with the tx_send pulse.
                if (ex_cnt_q == '0) begin
                    lo_d      = alu_lo;
                    hi_d      = alu_hi;
                    tx_word_d = alu_lo;
                    state_d   = ST_SEND_LO;
                end else begin
                    ex_cnt_d = ex_cnt_q - EW'(1);
                end
            end
            ST_SEND_LO: begin
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (tx_done) begin
                    if (SEND_HI) begin
                        tx_word_d = hi_q;
                        state_d   = ST_SEND_HI;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SEND_HI: begin
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Words arriving while a result is being computed or sent are lost.
        if (word_valid && (state_q inside {ST_EXEC, ST_SEND_LO, ST_WAIT_LO,
                                           ST_SEND_HI, ST_WAIT_HI})) begin
            overrun_d = 1'b1;
        end

        tx_send_d = (state_d == ST_SEND_LO) || (state_d == ST_SEND_HI);
        busy_d    = state_d inside {ST_EXEC, ST_SEND_LO, ST_WAIT_LO,
                                    ST_SEND_HI, ST_WAIT_HI};
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            tx_word_q   <= '0;
            tx_send_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            to_cnt_q    <= '0;
            ex_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            tx_word_q   <= tx_word_d;
            tx_send_q   <= tx_send_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            to_cnt_q    <= to_cnt_d;
            ex_cnt_q    <= ex_cnt_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign tx_word   = tx_word_q;
    assign tx_send   = tx_send_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign state     = state_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb/tb_calc_seq_ctrl.sv - self-checking bench for calc_seq_ctrl
module tb_calc_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] word_in;
    logic        wv_a, wv_b, done_a, done_b;

    logic [31:0] alu_a_a, alu_b_a, alu_lo_a, alu_hi_a, tx_word_a;
    logic [3:0]  alu_op_a;
    logic        tx_send_a, busy_a, frame_err_a, overrun_a;
    logic [2:0]  state_a;
    logic [31:0] alu_a_b, alu_b_b, alu_lo_b, alu_hi_b, tx_word_b;
    logic [3:0]  alu_op_b;
    logic        tx_send_b, busy_b, frame_err_b, overrun_b;
    logic [2:0]  state_b;

    // Reference ALU: 64-bit results so the hi word is meaningful.
    function automatic logic [63:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        case (op)
            4'd0:    return {32'd0, a} + {32'd0, b};
            4'd1:    return {32'd0, a} - {32'd0, b};
            4'd2:    return {32'd0, a ^ b};
            4'd3:    return {32'd0, a} * {32'd0, b};
            default: return {a, b};
        endcase
    endfunction

    logic [63:0] res_a, res_b;
    assign res_a    = alu_model(alu_a_a, alu_b_a, alu_op_a);
    assign alu_lo_a = res_a[31:0];
    assign alu_hi_a = res_a[63:32];
    assign res_b    = alu_model(alu_a_b, alu_b_b, alu_op_b);
    assign alu_lo_b = res_b[31:0];
    assign alu_hi_b = res_b[63:32];

    calc_seq_ctrl #(.EXEC_CYCLES(3), .TIMEOUT_CYCLES(16), .SEND_HI(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(wv_a),
        .alu_a(alu_a_a), .alu_b(alu_b_a), .alu_op(alu_op_a),
        .alu_lo(alu_lo_a), .alu_hi(alu_hi_a), .tx_word(tx_word_a),
        .tx_send(tx_send_a), .tx_done(done_a), .busy(busy_a),
        .frame_err(frame_err_a), .overrun(overrun_a), .state(state_a)
    );

    calc_seq_ctrl #(.EXEC_CYCLES(1), .TIMEOUT_CYCLES(16), .SEND_HI(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(wv_b),
        .alu_a(alu_a_b), .alu_b(alu_b_b), .alu_op(alu_op_b),
        .alu_lo(alu_lo_b), .alu_hi(alu_hi_b), .tx_word(tx_word_b),
        .tx_send(tx_send_b), .tx_done(done_b), .busy(busy_b),
        .frame_err(frame_err_b), .overrun(overrun_b), .state(state_b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] sent_w_a[$], sent_w_b[$];
    int          sent_c_a[$], sent_c_b[$];
    int          ferr_a = 0, ferr_b = 0, ovr_a = 0, ovr_b = 0;

    // Event log of every tx_send / frame_err / overrun pulse.
    always @(negedge clk) begin
        if (tx_send_a) begin sent_w_a.push_back(tx_word_a); sent_c_a.push_back(cyc); end
        if (tx_send_b) begin sent_w_b.push_back(tx_word_b); sent_c_b.push_back(cyc); end
        if (frame_err_a) ferr_a = ferr_a + 1;
        if (frame_err_b) ferr_b = ferr_b + 1;
        if (overrun_a) ovr_a = ovr_a + 1;
        if (overrun_b) ovr_b = ovr_b + 1;
    end

    function automatic int send_cnt(input int w);
        return (w == 0) ? sent_w_a.size() : sent_w_b.size();
    endfunction
    function automatic logic [31:0] sent_word(input int w, input int i);
        return (w == 0) ? sent_w_a[i] : sent_w_b[i];
    endfunction
    function automatic int sent_cyc(input int w, input int i);
        return (w == 0) ? sent_c_a[i] : sent_c_b[i];
    endfunction
    function automatic logic [2:0] st(input int w);
        return (w == 0) ? state_a : state_b;
    endfunction
    function automatic logic bsy(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction
    function automatic int exec_of(input int w);
        return (w == 0) ? 3 : 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input int w, input logic [31:0] d);
        word_in = d;
        if (w == 0) wv_a = 1'b1; else wv_b = 1'b1;
        @(posedge clk); #1;
        wv_a = 1'b0; wv_b = 1'b0;
    endtask

    task automatic pulse_done(input int w);
        if (w == 0) done_a = 1'b1; else done_b = 1'b1;
        @(posedge clk); #1;
        done_a = 1'b0; done_b = 1'b0;
    endtask

    task automatic send_frame(input int w, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] op, input int gap,
                              output int t3, output int n0);
        send_word(w, a);
        tick(gap);
        send_word(w, b);
        tick(gap);
        n0 = send_cnt(w);
        t3 = cyc;
        send_word(w, op);
    endtask

    // Waits for send number n_before, checks its latency window and word.
    task automatic expect_tx(input int w, input int n_before, input int ref_cyc,
                             input int min_lat, input int max_lat,
                             input logic [31:0] exp_w, input string name);
        bit ok;
        int lat;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (send_cnt(w) > n_before) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_arrive: no tx_send within 40 cycles", name);
        end else begin
            lat = sent_cyc(w, n_before) - ref_cyc;
            checks++;
            if (lat < min_lat || lat > max_lat) begin
                failures++;
                $display("FAIL %s_latency: got %0d want %0d..%0d", name, lat, min_lat, max_lat);
            end
            checks++;
            if (sent_word(w, n_before) !== exp_w) begin
                failures++;
                $display("FAIL %s_word: got %h want %h", name, sent_word(w, n_before), exp_w);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_ops(input int w, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] op, input string name);
        logic [31:0] ga, gb;
        logic [3:0]  go;
        ga = (w == 0) ? alu_a_a : alu_a_b;
        gb = (w == 0) ? alu_b_a : alu_b_b;
        go = (w == 0) ? alu_op_a : alu_op_b;
        checks++;
        if (ga !== a || gb !== b || go !== op) begin
            failures++;
            $display("FAIL %s_operands: got a=%h b=%h op=%h want a=%h b=%h op=%h",
                     name, ga, gb, go, a, b, op);
        end
    endtask

    task automatic check_idle(input int w, input string name);
        checks++;
        if (st(w) !== 3'd0 || bsy(w) !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: got state=%0d busy=%b want 0/0", name, st(w), bsy(w));
        end
    endtask

    // Transmission phase of a frame, ending one cycle after the final tx_done.
    task automatic complete_tx(input int w, input int n0, input int t3,
                               input logic [63:0] res, input string name);
        int td;
        expect_tx(w, n0, t3, exec_of(w) + 1, exec_of(w) + 1, res[31:0], {name, "_lo"});
        tick($urandom_range(0, 3));
        td = cyc;
        pulse_done(w);
        if (w == 0) begin
            expect_tx(w, n0 + 1, td, 1, 2, res[63:32], {name, "_hi"});
            tick($urandom_range(0, 3));
            td = cyc;
            pulse_done(w);
        end
        check_idle(w, name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        checks++;
        if (alu_a_a !== 0 || alu_b_a !== 0 || alu_op_a !== 0 || tx_word_a !== 0 ||
            tx_send_a !== 0 || busy_a !== 0 || frame_err_a !== 0 || overrun_a !== 0 ||
            state_a !== 0) begin
            failures++;
            $display("FAIL reset_outputs: a=%h b=%h op=%h txw=%h send=%b busy=%b ferr=%b ovr=%b st=%0d want all 0",
                     alu_a_a, alu_b_a, alu_op_a, tx_word_a, tx_send_a, busy_a,
                     frame_err_a, overrun_a, state_a);
        end
    endtask

    task automatic test_basic();
        int t3, n0;
        send_frame(0, 32'd7, 32'd5, 32'd0, 0, t3, n0);
        check_ops(0, 32'd7, 32'd5, 4'd0, "basic");
        checks++;
        if (state_a !== 3'd3 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL basic_exec: got state=%0d busy=%b want 3/1", state_a, busy_a);
        end
        complete_tx(0, n0, t3, {32'd0, 32'd12}, "basic");
    endtask

    task automatic test_lo_only();
        int t3, n0;
        send_frame(1, 32'hFFFF_FFFF, 32'd2, 32'd3, 0, t3, n0);
        check_ops(1, 32'hFFFF_FFFF, 32'd2, 4'd3, "lo_only");
        complete_tx(1, n0, t3, {32'd1, 32'hFFFF_FFFE}, "lo_only");
        tick(8);
        checks++;
        if (send_cnt(1) != n0 + 1) begin
            failures++;
            $display("FAIL lo_only_count: got %0d sends want 1", send_cnt(1) - n0);
        end
    endtask

    task automatic test_timeout();
        int f0, t3, n0;
        f0 = ferr_a;
        send_word(0, 32'd9);
        tick(15);
        checks++;
        if (state_a !== 3'd1 || frame_err_a !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: got state=%0d ferr=%b want 1/0", state_a, frame_err_a);
        end
        tick(1);
        checks++;
        if (state_a !== 3'd0 || frame_err_a !== 1'b1) begin
            failures++;
            $display("FAIL timeout_fire: got state=%0d ferr=%b want 0/1", state_a, frame_err_a);
        end
        tick(5);
        checks++;
        if (ferr_a - f0 != 1 || alu_a_a !== 32'd9) begin
            failures++;
            $display("FAIL timeout_once: got pulses=%0d alu_a=%h want 1/9", ferr_a - f0, alu_a_a);
        end
        send_frame(0, 32'd1, 32'd2, 32'd0, 0, t3, n0);
        check_ops(0, 32'd1, 32'd2, 4'd0, "after_timeout");
        complete_tx(0, n0, t3, {32'd0, 32'd3}, "after_timeout");
    endtask

    task automatic test_timeout_coincide();
        int f0, t3, n0;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        f0 = ferr_a;
        send_word(0, a);
        send_word(0, b);
        tick(15);
        n0 = send_cnt(0);
        t3 = cyc;
        send_word(0, 32'h0000_0012);
        checks++;
        if (state_a !== 3'd3 || frame_err_a !== 1'b0) begin
            failures++;
            $display("FAIL coincide_accept: got state=%0d ferr=%b want 3/0", state_a, frame_err_a);
        end
        check_ops(0, a, b, 4'd2, "coincide");
        complete_tx(0, n0, t3, alu_model(a, b, 4'd2), "coincide");
        checks++;
        if (ferr_a != f0) begin
            failures++;
            $display("FAIL coincide_noerr: got %0d frame_err pulses want 0", ferr_a - f0);
        end
    endtask

    task automatic test_overrun();
        int o0, t3, n0, td;
        logic [31:0] a, b;
        logic [63:0] res;
        a = $urandom; b = $urandom;
        res = alu_model(a, b, 4'd1);
        o0 = ovr_a;
        send_frame(0, a, b, 32'hABCD_EF01, 1, t3, n0);
        send_word(0, 32'hDEAD_BEEF);
        check_ops(0, a, b, 4'd1, "ovr_exec");
        expect_tx(0, n0, t3, 4, 4, res[31:0], "ovr_lo");
        send_word(0, $urandom);
        checks++;
        if (state_a !== 3'd5 || tx_word_a !== res[31:0]) begin
            failures++;
            $display("FAIL ovr_wait_lo: got state=%0d txw=%h want 5/%h", state_a, tx_word_a, res[31:0]);
        end
        check_ops(0, a, b, 4'd1, "ovr_wait");
        tick(1);
        checks++;
        if (ovr_a - o0 != 2) begin
            failures++;
            $display("FAIL ovr_count: got %0d pulses want 2", ovr_a - o0);
        end
        td = cyc;
        pulse_done(0);
        expect_tx(0, n0 + 1, td, 1, 2, res[63:32], "ovr_hi");
        pulse_done(0);
        check_idle(0, "ovr");
    endtask

    task automatic test_reset_mid();
        int t3, n0, n1;
        send_frame(0, 32'd100, 32'd23, 32'd0, 0, t3, n0);
        expect_tx(0, n0, t3, 4, 4, 32'd123, "rst_lo");
        n1 = send_cnt(0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        checks++;
        if (alu_a_a !== 0 || alu_b_a !== 0 || alu_op_a !== 0 || tx_word_a !== 0 ||
            busy_a !== 0 || state_a !== 0 || tx_send_a !== 0) begin
            failures++;
            $display("FAIL rst_mid_outputs: a=%h b=%h op=%h txw=%h busy=%b st=%0d send=%b want all 0",
                     alu_a_a, alu_b_a, alu_op_a, tx_word_a, busy_a, state_a, tx_send_a);
        end
        pulse_done(0);
        tick(10);
        checks++;
        if (send_cnt(0) != n1 || state_a !== 3'd0) begin
            failures++;
            $display("FAIL rst_mid_spurious: got %0d extra sends state=%0d want 0/0",
                     send_cnt(0) - n1, state_a);
        end
        send_frame(0, 32'd4, 32'd6, 32'd2, 0, t3, n0);
        check_ops(0, 32'd4, 32'd6, 4'd2, "after_rst");
        complete_tx(0, n0, t3, {32'd0, 32'd2}, "after_rst");
    endtask

    task automatic test_back_to_back();
        int t3, n0, w, f0;
        logic [31:0] a, b, op;
        f0 = ferr_a + ferr_b;
        for (int i = 0; i < 20; i++) begin
            w  = $urandom_range(0, 1);
            a  = $urandom; b = $urandom; op = $urandom;
            send_frame(w, a, b, op, $urandom_range(0, 14), t3, n0);
            check_ops(w, a, b, op[3:0], "rand");
            complete_tx(w, n0, t3, alu_model(a, b, op[3:0]), "rand");
        end
        checks++;
        if (ferr_a + ferr_b != f0) begin
            failures++;
            $display("FAIL rand_noerr: got %0d frame_err pulses want 0", ferr_a + ferr_b - f0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; word_in = '0; wv_a = 1'b0; wv_b = 1'b0; done_a = 1'b0; done_b = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_lo_only();
        test_timeout();
        test_timeout_coincide();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
